// File: rtl/uart_arb_pkg.sv
// Shared state type, default timeout and round-robin helper for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} arb_state_t;

  localparam int IDLE_TIMEOUT_DEF = 1024;

  function automatic int unsigned next_rr(input int unsigned ptr, input int unsigned n);
    return (ptr >= n - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin search: first set request after ptr_i, wrapping modulo N.
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int N = 3,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  always_comb begin
    int unsigned p;
    logic [W-1:0] c;
    found_o = 1'b0;
    idx_o   = '0;
    p       = 32'(ptr_i);
    c       = '0;
    for (int k = 0; k < N; k++) begin
      p = next_rr(p, unsigned'(N));
      c = W'(p);
      if (!found_o && req_i[c]) begin
        found_o = 1'b1;
        idx_o   = c;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular arbiter sharing one UART_Tx among NUM_REQ byte-stream requesters.
// UART_ARB_PRIO0_EN: requester 0 wins every arbitration it is valid in; others stay round-robin.
//   state | meaning
//   IDLE  | no owner; arbitrate among valid requesters
//   SEND  | owner holds grant; waiting for its next byte (watchdog running)
//   WAIT  | byte handed to UART_Tx; waiting for tx_done
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [NUM_REQ-1:0][7:0] req_data_i,
  input  logic [NUM_REQ-1:0]      req_last_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic                    tx_start_o,
  output logic [7:0]              tx_data_o,
  input  logic                    tx_busy_i,
  input  logic                    tx_done_i,
  output logic                    grant_valid_o,
  output logic [ID_W-1:0]         grant_id_o,
  output logic                    pkt_done_o,
  output logic                    pkt_abort_o
);

  localparam int CNT_W = $clog2(IDLE_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_TIMEOUT - 1);

  arb_state_t       state_q, state_d;
  logic             grant_valid_q, grant_valid_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             last_q, last_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             pkt_done_q, pkt_done_d;
  logic             pkt_abort_q, pkt_abort_d;

  logic [NUM_REQ-1:0] pick_req;
  logic               pick_found, arb_found;
  logic [ID_W-1:0]    pick_idx, arb_idx, rel_ptr;

`ifdef UART_ARB_PRIO0_EN
  // Requester 0 bypasses the rotation and never moves the pointer.
  always_comb begin
    pick_req    = req_valid_i;
    pick_req[0] = 1'b0;
    arb_found   = pick_found;
    arb_idx     = pick_idx;
    if (req_valid_i[0]) begin
      arb_found = 1'b1;
      arb_idx   = '0;
    end
    rel_ptr = (grant_id_q != '0) ? grant_id_q : rr_ptr_q;
  end
`else
  always_comb begin
    pick_req  = req_valid_i;
    arb_found = pick_found;
    arb_idx   = pick_idx;
    rel_ptr   = grant_id_q;
  end
`endif

  rr_picker #(.N(NUM_REQ)) u_picker (
    .req_i   (pick_req),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    req_ready_o = '0;
    if (state_q == SEND && grant_valid_q && !tx_busy_i) req_ready_o[grant_id_q] = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    idle_cnt_d    = idle_cnt_q;
    last_d        = last_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    pkt_done_d    = 1'b0;
    pkt_abort_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_id_d    = arb_idx;
          grant_valid_d = 1'b1;
          idle_cnt_d    = '0;
          state_d       = SEND;
        end
      end
      SEND: begin
        if (req_valid_i[grant_id_q] && req_ready_o[grant_id_q]) begin
          tx_data_d  = req_data_i[grant_id_q];
          tx_start_d = 1'b1;
          last_d     = req_last_i[grant_id_q];
          idle_cnt_d = '0;
          state_d    = WAIT;
        end else if (!tx_busy_i) begin
          // Owner silent while the UART is free: watchdog runs.
          if (idle_cnt_q == CNT_LAST) begin
            pkt_abort_d   = 1'b1;
            grant_valid_d = 1'b0;
            rr_ptr_d      = rel_ptr;
            state_d       = IDLE;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      WAIT: begin
        if (tx_done_i) begin
          if (last_q) begin
            pkt_done_d    = 1'b1;
            grant_valid_d = 1'b0;
            rr_ptr_d      = rel_ptr;
            state_d       = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      rr_ptr_q      <= ID_W'(NUM_REQ - 1);
      idle_cnt_q    <= '0;
      last_q        <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      pkt_done_q    <= 1'b0;
      pkt_abort_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      idle_cnt_q    <= idle_cnt_d;
      last_q        <= last_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      pkt_done_q    <= pkt_done_d;
      pkt_abort_q   <= pkt_abort_d;
    end
  end

  assign tx_start_o    = tx_start_q;
  assign tx_data_o     = tx_data_q;
  assign grant_valid_o = grant_valid_q;
  assign grant_id_o    = grant_id_q;
  assign pkt_done_o    = pkt_done_q;
  assign pkt_abort_o   = pkt_abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed packet scenarios plus randomized traffic against a packet-level model.
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int TO = 16;
  localparam int QD = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid_i, req_last_i, req_ready_o;
  logic [N-1:0][7:0] req_data_i;
  logic            tx_start_o, tx_busy_i, tx_done_i, grant_valid_o, pkt_done_o, pkt_abort_o;
  logic [7:0]      tx_data_o;
  logic [1:0]      grant_id_o;

  uart_tx_arbiter #(.NUM_REQ(N), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o),
    .tx_start_o(tx_start_o), .tx_data_o(tx_data_o), .tx_busy_i(tx_busy_i), .tx_done_i(tx_done_i),
    .grant_valid_o(grant_valid_o), .grant_id_o(grant_id_o),
    .pkt_done_o(pkt_done_o), .pkt_abort_o(pkt_abort_o)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Requester byte queues: {last, data}
  logic [8:0] rq_mem [N][QD];
  int rq_h [N], rq_t [N], stall [N];
  logic [N-1:0] acc;

  // Packet-level reference: who owns the UART, whether a byte is on the line,
  // how long the owner has been silent, and where the rotation resumes.
  int m_owner, m_ptr, m_idle, abort_who;
  bit m_inflight, m_last, e_start, e_done, e_abort, pre_inflight_g;
  logic [7:0] m_txd;

  int u_cnt;
  bit noise, gen_en, eager, gv_prev;
  int glog [32];
  logic [7:0] tlog [64];
  int gn, tn, done_n, abort_n, abort_cyc, last_done_cyc;

  function automatic int pick(input logic [N-1:0] v, input int ptr);
`ifdef UART_ARB_PRIO0_EN
    if (v[0]) return 0;
    v[0] = 1'b0;
`endif
    for (int k = 1; k <= N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic release_owner();
`ifdef UART_ARB_PRIO0_EN
    if (m_owner != 0) m_ptr = m_owner;
`else
    m_ptr = m_owner;
`endif
    m_owner = -1;
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input bit l);
    rq_mem[r][rq_t[r] % QD] = {l, d};
    rq_t[r]++;
  endtask

  task automatic push_rand_pkt(input int r, input int len);
    for (int j = 0; j < len; j++) push_byte(r, 8'($urandom), j == len - 1);
  endtask

  task automatic init_model();
    m_owner = -1; m_ptr = N - 1; m_idle = 0; m_inflight = 0; m_last = 0;
    e_start = 0; e_done = 0; e_abort = 0; m_txd = '0; gv_prev = 0;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin rq_h[i] = rq_t[i]; stall[i] = 0; end
    req_valid_i = '0; acc = '0;
  endtask

  task automatic clear_logs();
    gn = 0; tn = 0; done_n = 0; abort_n = 0; abort_cyc = -1; last_done_cyc = -1;
  endtask

  task automatic step();
    logic [N-1:0] exp_rdy;
    logic [8:0] hd;
    @(negedge clk);
    cyc++;
    chk("tx_start", 32'(tx_start_o), 32'(e_start));
    chk("tx_data", 32'(tx_data_o), 32'(m_txd));
    chk("grant_valid", 32'(grant_valid_o), 32'(m_owner >= 0));
    if (m_owner >= 0) chk("grant_id", 32'(grant_id_o), m_owner);
    chk("pkt_done", 32'(pkt_done_o), 32'(e_done));
    chk("pkt_abort", 32'(pkt_abort_o), 32'(e_abort));

    if (tx_start_o && tn < 64) begin tlog[tn] = tx_data_o; tn++; end
    if (grant_valid_o && !gv_prev && gn < 32) begin glog[gn] = int'(grant_id_o); gn++; end
    gv_prev = grant_valid_o;
    if (pkt_done_o) done_n++;
    if (pkt_abort_o) begin abort_n++; abort_cyc = cyc; end

    for (int i = 0; i < N; i++) if (acc[i]) begin
      hd = rq_mem[i][rq_h[i] % QD];
      rq_h[i]++;
      if (noise && !hd[8] && $urandom_range(0, 31) == 0) stall[i] = $urandom_range(10, 25);
    end
    if (e_abort) begin
      while (rq_t[abort_who] != rq_h[abort_who]) begin
        hd = rq_mem[abort_who][rq_h[abort_who] % QD];
        rq_h[abort_who]++;
        if (hd[8]) break;
      end
    end

    tx_done_i = 1'b0;
    if (tx_start_o) u_cnt = $urandom_range(1, 4);
    if (u_cnt > 0) begin
      u_cnt--;
      tx_busy_i = (u_cnt != 0);
      tx_done_i = (u_cnt == 0);
      if (u_cnt == 0) last_done_cyc = cyc;
    end else begin
      tx_busy_i = noise && ($urandom_range(0, 7) == 0);
      tx_done_i = noise && ($urandom_range(0, 15) == 0);
    end

    if (gen_en)
      for (int i = 0; i < N; i++)
        if (rq_t[i] - rq_h[i] < 16 && $urandom_range(0, 7) == 0) push_rand_pkt(i, $urandom_range(1, 5));

    for (int i = 0; i < N; i++) begin
      if (!(req_valid_i[i] && !acc[i])) begin
        if (stall[i] > 0) begin stall[i]--; req_valid_i[i] = 1'b0; end
        else req_valid_i[i] = (rq_t[i] != rq_h[i]) && (eager || $urandom_range(0, 3) != 0);
        if (req_valid_i[i]) begin
          hd = rq_mem[i][rq_h[i] % QD];
          req_data_i[i] = hd[7:0];
          req_last_i[i] = hd[8];
        end else begin
          req_data_i[i] = 8'($urandom);
          req_last_i[i] = 1'($urandom);
        end
      end
    end

    #1;
    exp_rdy = '0;
    if (m_owner >= 0 && !m_inflight && !tx_busy_i) exp_rdy[m_owner] = 1'b1;
    chk("req_ready", 32'(req_ready_o), 32'(exp_rdy));
    acc = req_valid_i & req_ready_o;

    pre_inflight_g = m_inflight;
    e_start = 0; e_done = 0; e_abort = 0;
    if (m_owner < 0) begin
      if (req_valid_i != '0) begin m_owner = pick(req_valid_i, m_ptr); m_idle = 0; end
    end else if (!m_inflight) begin
      if (!tx_busy_i) begin
        if (req_valid_i[m_owner]) begin
          e_start = 1; m_txd = req_data_i[m_owner]; m_last = req_last_i[m_owner];
          m_inflight = 1; m_idle = 0;
        end else if (m_idle == TO - 1) begin
          e_abort = 1; abort_who = m_owner; release_owner();
        end else begin
          m_idle++;
        end
      end
    end else if (tx_done_i) begin
      m_inflight = 0;
      if (m_last) begin e_done = 1; release_owner(); end
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic chk_reset_vals();
    chk("rst_tx_start", 32'(tx_start_o), 0);
    chk("rst_tx_data", 32'(tx_data_o), 0);
    chk("rst_grant_valid", 32'(grant_valid_o), 0);
    chk("rst_grant_id", 32'(grant_id_o), 0);
    chk("rst_pkt_done", 32'(pkt_done_o), 0);
    chk("rst_pkt_abort", 32'(pkt_abort_o), 0);
    chk("rst_req_ready", 32'(req_ready_o), 0);
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    init_model(); clear_reqs(); clear_logs();
    tx_busy_i = 1'b0; tx_done_i = 1'b0; u_cnt = 0;
    noise = 0; gen_en = 0; eager = 1;
    #1 chk_reset_vals();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic reset_mid_wait();
    int k, d0, t0;
    k = 0;
    while (!(pre_inflight_g && m_inflight) && k < 300) begin step(); k++; end
    chk("reach_wait", 32'(pre_inflight_g && m_inflight), 1);
    gen_en = 0;
    #1 reset = 1'b1;
    #1 chk_reset_vals();
    init_model(); clear_reqs();
    u_cnt = 3; tx_busy_i = 1'b1; tx_done_i = 1'b0;
    #1 reset = 1'b0;
    d0 = done_n; t0 = tn;
    run(8);
    chk("stray_done_no_pkt_done", done_n - d0, 0);
    chk("stray_done_no_tx_start", tn - t0, 0);
    gen_en = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    int exp_rr [6];
    req_valid_i = '0; req_data_i = '0; req_last_i = '0; tx_busy_i = 0; tx_done_i = 0;
    for (int i = 0; i < N; i++) begin rq_h[i] = 0; rq_t[i] = 0; end
    pre_inflight_g = 0; abort_who = 0;

    // Single three-byte packet from requester 0
    do_reset();
    push_byte(0, 8'hFF, 0); push_byte(0, 8'h12, 0); push_byte(0, 8'h34, 1);
    run(40);
    chk("a_bytes", tn, 3);
    chk("a_byte0", 32'(tlog[0]), 32'hFF);
    chk("a_byte1", 32'(tlog[1]), 32'h12);
    chk("a_byte2", 32'(tlog[2]), 32'h34);
    chk("a_pkt_done", done_n, 1);
    chk("a_grant", glog[0], 0);
    chk("a_released", 32'(grant_valid_o), 0);

    // Three requesters, two 2-byte packets each
    do_reset();
    for (int i = 0; i < N; i++) begin push_rand_pkt(i, 2); push_rand_pkt(i, 2); end
    run(150);
`ifdef UART_ARB_PRIO0_EN
    exp_rr = '{0, 0, 1, 2, 1, 2};
`else
    exp_rr = '{0, 1, 2, 0, 1, 2};
`endif
    chk("b_grants", gn, 6);
    for (int i = 0; i < 6; i++) chk("b_order", glog[i], exp_rr[i]);
    chk("b_pkt_done", done_n, 6);

    // Owner locking: requester 1 holds while 0 and 2 queue up
    do_reset();
    push_byte(1, 8'hA0, 0); push_byte(1, 8'hA1, 0); push_byte(1, 8'hA2, 0); push_byte(1, 8'hA3, 1);
    k = 0;
    while (tn < 1 && k < 50) begin step(); k++; end
    chk("c_first_byte", tn, 1);
    push_rand_pkt(0, 2); push_rand_pkt(2, 1);
    run(100);
    chk("c_grants", gn, 3);
    chk("c_owner0", glog[0], 1);
`ifdef UART_ARB_PRIO0_EN
    chk("c_owner1", glog[1], 0);
    chk("c_owner2", glog[2], 2);
`else
    chk("c_owner1", glog[1], 2);
    chk("c_owner2", glog[2], 0);
`endif
    for (int i = 0; i < 4; i++) chk("c_req1_bytes", 32'(tlog[i]), 32'(8'hA0 + 8'(i)));

    // Watchdog: requester 2 sends one non-last byte then goes silent
    do_reset();
    push_byte(2, 8'h5A, 0);
    k = 0;
    while (abort_n == 0 && k < 100) begin step(); k++; end
    chk("d_abort_seen", abort_n, 1);
    // done cycle itself plus the 16 silent SEND cycles
    chk("d_abort_latency", abort_cyc - last_done_cyc, TO + 1);
    chk("d_no_pkt_done", done_n, 0);
    push_rand_pkt(0, 1); push_rand_pkt(1, 1);
    run(40);
    chk("d_grants", gn, 3);
    chk("d_after_abort", glog[1], 0);
    chk("d_then", glog[2], 1);

`ifdef UART_ARB_PRIO0_EN
    // Requester 0 wins every boundary while it keeps packets queued
    do_reset();
    for (int i = 0; i < 3; i++) push_rand_pkt(0, 2);
    for (int i = 0; i < 2; i++) push_rand_pkt(1, 2);
    run(120);
    chk("e_grants", gn, 5);
    for (int i = 0; i < 5; i++) chk("e_order", glog[i], (i < 3) ? 0 : 1);
`endif

    // Randomized traffic with UART stalls, stray tx_done and requester stalls
    do_reset();
    noise = 1; gen_en = 1; eager = 0;
    run(1500);
    reset_mid_wait();
    run(2500);
    chk("r_progress", 32'(done_n > 20), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter between several byte-stream requesters: telemetry packet sender, image dump sender and debug/console. Arbitration is packet-granular; a winner holds the transmitter until its byte flagged last completes.
- Default policy: round-robin.
- Stalled-packet watchdog releases the grant if the holder stops supplying bytes.
- Sits between the game-logic senders and the single UART_Tx instance in the top level.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
IDLE_TIMEOUT, 1024, cycles a granted requester may hold SEND without req_valid before abort (>=2)
ID_W, $clog2(NUM_REQ), width of grant_id (derived; not overridden)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  requester i has a byte ready
req_data  in  NUM_REQ x 8  byte from requester i
req_last  in  NUM_REQ  byte is final byte of requester i's packet
req_ready  out  NUM_REQ  byte of requester i accepted this cycle
tx_start  out  1  one-cycle start pulse to UART_Tx
tx_data  out  8  byte to UART_Tx, held stable until next start
tx_busy  in  1  UART_Tx busy
tx_done  in  1  UART_Tx one-cycle byte-complete pulse
grant_valid  out  1  a requester currently owns the UART
grant_id  out  ID_W  current owner index
pkt_done  out  1  one-cycle pulse: owner's last byte finished
pkt_abort  out  1  one-cycle pulse: owner timed out, grant released

Behaviour:
- Clock domain and reset: single clock domain. Reset is async, active-high.
- Reset values: state=IDLE; tx_start=0, tx_data=0, grant_valid=0, grant_id=0, pkt_done=0, pkt_abort=0; rr_ptr=NUM_REQ-1; idle_cnt=0.
- Reset mid-packet: the UART is not flushed. A byte already in UART_Tx completes on the line. A tx_done arriving after reset is ignored in IDLE.
- States: IDLE, SEND, WAIT.
- IDLE:
  - If any req_valid, pick the first asserted index searching rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
  - Register grant_id, set grant_valid=1, clear idle_cnt, go to SEND.
  - Arbitration costs one cycle; no byte is accepted in IDLE.
- SEND:
  - req_ready[i] is combinational: (state==SEND) && grant_valid && (grant_id==i) && !tx_busy. All other bits are 0.
  - Byte transfer: when req_valid[grant_id] && req_ready[grant_id]:
    - tx_data<=req_data[grant_id]; tx_start<=1 for exactly one cycle;
    - last_q<=req_last[grant_id]; idle_cnt<=0; go to WAIT.
  - If req_valid[grant_id]=0: idle_cnt++. When idle_cnt reaches IDLE_TIMEOUT-1:
    - pkt_abort pulse; grant_valid<=0; rr_ptr<=grant_id; go to IDLE.
  - tx_busy high in SEND: stay, no start, idle_cnt not incremented.
- WAIT: ignore requester inputs until tx_done.
  - On tx_done with last_q=1: pkt_done pulse; grant_valid<=0; rr_ptr<=grant_id; go to IDLE.
  - On tx_done with last_q=0: go to SEND.
- Minimum gap between bytes of one packet: tx_done cycle plus 1 cycle (SEND).
- Non-owners' req_valid is ignored while a grant is held. Requesters must keep valid/data stable until ready.
- Single-byte packet (last on first byte) is legal. Back-to-back packets from the same requester go through IDLE and re-arbitration.
- tx_data retains its last value when not starting. A tx_done outside WAIT is ignored.

Optional Feature:
UART_ARB_PRIO0_EN
- Defined: requester 0 (telemetry) wins every IDLE arbitration in which it is valid. Others use round-robin among themselves; rr_ptr is updated only by non-zero owners. Preemption mid-packet is never allowed.
- Undefined: pure round-robin as above.

Decomposition:
- Package uart_arb_pkg holds:
  - arb_state_t enum {IDLE, SEND, WAIT};
  - localparam default IDLE_TIMEOUT;
  - function next_rr(ptr, n) for modulo increment.
- One sub-module, rr_picker (combinational: req vector + rr_ptr -> found, index), makes round-robin searching reusable and unit-testable. The FSM, counters and muxing stay in uart_tx_arbiter.

Test Plan:
- Single-requester packet: req0 sends 3 bytes 0xFF,0x12,0x34 (last on 0x34) -> three tx_start pulses in order; tx_data matches each; pkt_done once after third tx_done; grant_valid falls; grant_id=0.
- Round-robin fairness: req0, req1, req2 all continuously valid with 2-byte packets -> grant order 0,1,2,0,1,2; no interleaving of bytes across owners.
- Locking: req1 owns and sends a 4-byte packet; req0 asserts valid after byte 1 -> req_ready[0] stays 0 until req1's pkt_done; next grant goes to req2 if valid, else req0.
- Timeout: IDLE_TIMEOUT=16; req2 granted, sends one non-last byte, then drops valid -> pkt_abort pulses exactly 16 SEND cycles later; state IDLE; rr_ptr=2.
- Async reset mid-WAIT: assert reset while byte 2 of 5 is in UART -> all outputs go to reset values immediately; a stray tx_done after reset produces no tx_start and no pkt_done.
- With UART_ARB_PRIO0_EN: req1 and req0 both valid at every IDLE -> req0 wins each packet boundary; req1 is served only when req0 is idle at arbitration.
